// File: rtl/dma_engine_pkg.sv
// Shared definitions for the CPCI DMA engine transfer scheduler:
// FSM encoding and MAC index sizing.
package dma_engine_pkg;

  localparam int MAC_W = 4;
  localparam int MAC_N = 16;

  localparam logic [3:0] CONSEC_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_XFER = 2'd1,
    WR_XFER = 2'd2,
    GAP     = 2'd3
  } xfer_state_e;

endpackage

// File: rtl/dma_xfer_watchdog.sv
// Per-transfer watchdog: clearable, loadable up-counter whose terminal count
// marks TIMEOUT_CYCLES-1 cycles of activity.
module dma_xfer_watchdog #(
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int CW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dma_engine_xfer_sched.sv
// Read/write direction scheduler for the CPCI DMA engine with weighted
// fairness, watchdog abort and CNET-reprogram abort. Optional statistics
// counters are enabled with DMA_XFER_SCHED_STATS_EN.
module dma_engine_xfer_sched
  import dma_engine_pkg::*;
#(
  parameter int RD_BURST       = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cnet_reprog,
  input  logic             rd_buf_avail,
  input  logic             rd_q_vld,
  input  logic [MAC_W-1:0] rd_q,
  input  logic             wr_req,
  input  logic [MAC_W-1:0] wr_mac,
  input  logic [MAC_N-1:0] cnet_tx_full,
  input  logic             ctrl_done,
  output logic             dma_rd_request,
  output logic [MAC_W-1:0] rd_mac,
  output logic             wr_start,
  output logic             wr_ack,
  output logic             xfer_is_rd,
  output logic             dma_in_progress,
  output logic [1:0]       xfer_state,
  output logic             xfer_timeout
`ifdef DMA_XFER_SCHED_STATS_EN
  ,
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count,
  output logic [15:0]      timeout_count
`endif
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  xfer_state_e state;
  logic [3:0]  consec_rd;
  logic        in_xfer;
  logic        rd_ok;
  logic        wr_ok;
  logic        grant_rd;
  logic        grant_wr;
  logic        wd_tc;

  // Handshake: wr_req is a level held by the driver until wr_ack; wr_ack is
  // a single-cycle pulse coincident with wr_start and consumes the request.
  assign rd_ok    = rd_buf_avail & rd_q_vld;
  assign wr_ok    = wr_req & ~cnet_tx_full[wr_mac];
  assign grant_rd = rd_ok & (~wr_ok | (consec_rd < 4'(RD_BURST)));
  assign grant_wr = wr_ok & ~grant_rd;
  assign in_xfer  = (state == RD_XFER) || (state == WR_XFER);

  assign xfer_state = state;

  dma_xfer_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (cnet_reprog),
    .load     ((state == IDLE) & (grant_rd | grant_wr)),
    .load_val ({WD_W{1'b0}}),
    .en       (in_xfer),
    .tc       (wd_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      consec_rd       <= 4'd0;
      dma_rd_request  <= 1'b0;
      rd_mac          <= '0;
      wr_start        <= 1'b0;
      wr_ack          <= 1'b0;
      xfer_is_rd      <= 1'b0;
      dma_in_progress <= 1'b0;
      xfer_timeout    <= 1'b0;
    end else begin
      dma_rd_request <= 1'b0;
      wr_start       <= 1'b0;
      wr_ack         <= 1'b0;
      xfer_timeout   <= 1'b0;
      if (cnet_reprog) begin
        state           <= IDLE;
        consec_rd       <= 4'd0;
        dma_in_progress <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (grant_rd) begin
              state           <= RD_XFER;
              dma_rd_request  <= 1'b1;
              rd_mac          <= rd_q;
              xfer_is_rd      <= 1'b1;
              dma_in_progress <= 1'b1;
              if (consec_rd != CONSEC_MAX) consec_rd <= consec_rd + 4'd1;
            end else if (grant_wr) begin
              state           <= WR_XFER;
              wr_start        <= 1'b1;
              wr_ack          <= 1'b1;
              xfer_is_rd      <= 1'b0;
              dma_in_progress <= 1'b1;
              consec_rd       <= 4'd0;
            end
          end
          RD_XFER, WR_XFER: begin
            // Completion beats the watchdog when both land in the same cycle.
            if (ctrl_done) begin
              state           <= GAP;
              dma_in_progress <= 1'b0;
            end else if (wd_tc) begin
              state           <= GAP;
              dma_in_progress <= 1'b0;
              xfer_timeout    <= 1'b1;
            end
          end
          GAP:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DMA_XFER_SCHED_STATS_EN
  // Statistics survive cnet_reprog; only reset_n clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count      <= 32'd0;
      wr_count      <= 32'd0;
      timeout_count <= 16'd0;
    end else begin
      if (dma_rd_request) rd_count      <= rd_count + 32'd1;
      if (wr_start)       wr_count      <= wr_count + 32'd1;
      if (xfer_timeout)   timeout_count <= timeout_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_engine_xfer_sched.sv
// Scoreboard bench for dma_engine_xfer_sched: a cycle-stepped transaction
// model predicts grant/timeout events; a monitor pops and compares them.
module tb_dma_engine_xfer_sched;

  localparam int RD_BURST = 2;
  localparam int TIMEOUT  = 8;
  localparam logic [3:0] K_RD = 4'b0001;
  localparam logic [3:0] K_WR = 4'b0110;
  localparam logic [3:0] K_TO = 4'b1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cnet_reprog, rd_buf_avail, rd_q_vld, wr_req, ctrl_done;
  logic [3:0]  rd_q, wr_mac;
  logic [15:0] cnet_tx_full;
  logic        dma_rd_request, wr_start, wr_ack, xfer_is_rd, dma_in_progress, xfer_timeout;
  logic [3:0]  rd_mac;
  logic [1:0]  xfer_state;
`ifdef DMA_XFER_SCHED_STATS_EN
  logic [31:0] rd_count, wr_count;
  logic [15:0] timeout_count;
`endif

  dma_engine_xfer_sched #(
    .RD_BURST       (RD_BURST),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cnet_reprog     (cnet_reprog),
    .rd_buf_avail    (rd_buf_avail),
    .rd_q_vld        (rd_q_vld),
    .rd_q            (rd_q),
    .wr_req          (wr_req),
    .wr_mac          (wr_mac),
    .cnet_tx_full    (cnet_tx_full),
    .ctrl_done       (ctrl_done),
    .dma_rd_request  (dma_rd_request),
    .rd_mac          (rd_mac),
    .wr_start        (wr_start),
    .wr_ack          (wr_ack),
    .xfer_is_rd      (xfer_is_rd),
    .dma_in_progress (dma_in_progress),
    .xfer_state      (xfer_state),
    .xfer_timeout    (xfer_timeout)
`ifdef DMA_XFER_SCHED_STATS_EN
    ,
    .rd_count        (rd_count),
    .wr_count        (wr_count),
    .timeout_count   (timeout_count)
`endif
  );

  // ---------------- clock / reset / cycle index ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // reference model: transfer-level view of the scheduler
  bit         m_busy, m_gap;
  int         m_age, m_run;
  logic       m_is_rd, m_dip;
  logic [3:0] m_rd_mac;
  logic       cur_is_rd, cur_dip;
  logic [3:0] cur_rd_mac;
  int         m_rd_n, m_wr_n, m_to_n;
  bit         wr_pend;
  logic [3:0] wr_mac_r;

  function automatic logic [31:0] ev(int c, logic [3:0] mac, logic [3:0] kind);
    return {c[23:0], mac, kind};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_gap = 0; m_age = 0; m_run = 0;
    m_is_rd = 0; m_dip = 0; m_rd_mac = 4'h0;
    cur_is_rd = 0; cur_dip = 0; cur_rd_mac = 4'h0;
    m_rd_n = 0; m_wr_n = 0; m_to_n = 0;
    exp_q.delete();
  endtask

  // Called once per cycle after inputs are applied; predicts next cycle.
  task automatic model_step();
    bit rd_ok, wr_ok;
    cur_dip = m_dip; cur_is_rd = m_is_rd; cur_rd_mac = m_rd_mac;
    if (cnet_reprog) begin
      m_busy = 0; m_gap = 0; m_run = 0; m_dip = 0;
    end else if (m_busy) begin
      if (ctrl_done) begin
        m_busy = 0; m_gap = 1; m_dip = 0;
      end else if (m_age == TIMEOUT - 1) begin
        exp_q.push_back(ev(cyc + 1, 4'h0, K_TO));
        m_busy = 0; m_gap = 1; m_dip = 0; m_to_n++;
      end else begin
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      rd_ok = rd_buf_avail && rd_q_vld;
      wr_ok = wr_req && !cnet_tx_full[wr_mac];
      if (rd_ok && !(wr_ok && m_run >= RD_BURST)) begin
        exp_q.push_back(ev(cyc + 1, rd_q, K_RD));
        m_rd_mac = rd_q; m_is_rd = 1; m_busy = 1; m_age = 0; m_dip = 1;
        if (m_run < 15) m_run++;
        m_rd_n++;
      end else if (wr_ok) begin
        exp_q.push_back(ev(cyc + 1, 4'h0, K_WR));
        m_is_rd = 0; m_busy = 1; m_age = 0; m_dip = 1; m_run = 0;
        wr_pend = 0; m_wr_n++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rba, input logic rqv, input logic [3:0] rq,
                       input logic wrq, input logic [3:0] wm, input logic [15:0] full,
                       input logic done, input logic rep);
    @(posedge clk); #1;
    rd_buf_avail = rba; rd_q_vld = rqv; rd_q = rq;
    wr_req = wrq; wr_mac = wm; cnet_tx_full = full;
    ctrl_done = done; cnet_reprog = rep;
    model_step();
  endtask

  task automatic quiet(input logic done);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 16'h0, done, 1'b0);
  endtask

  task automatic quiesce();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    quiet(1'b0);
  endtask

  task automatic rand_cycle();
    if (!wr_pend && $urandom_range(0, 2) == 0) begin
      wr_pend  = 1;
      wr_mac_r = 4'($urandom_range(0, 15));
    end
    drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
          wr_pend, wr_mac_r, 16'($urandom) & 16'($urandom),
          $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, ".dma_rd_request"},  dma_rd_request, 0);
    check({tag, ".rd_mac"},          rd_mac, 0);
    check({tag, ".wr_start"},        wr_start, 0);
    check({tag, ".wr_ack"},          wr_ack, 0);
    check({tag, ".xfer_is_rd"},      xfer_is_rd, 0);
    check({tag, ".dma_in_progress"}, dma_in_progress, 0);
    check({tag, ".xfer_timeout"},    xfer_timeout, 0);
`ifdef DMA_XFER_SCHED_STATS_EN
    check({tag, ".rd_count"},      rd_count, 0);
    check({tag, ".wr_count"},      wr_count, 0);
    check({tag, ".timeout_count"}, timeout_count, 0);
`endif
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [3:0]  kind;
    logic [31:0] got;
    logic [31:0] want;
    if (mon_en) begin
      check("dma_in_progress", dma_in_progress, cur_dip);
      check("xfer_is_rd", xfer_is_rd, cur_is_rd);
      check("rd_mac", rd_mac, cur_rd_mac);
      while (exp_q.size() > 0 && exp_q[0][31:8] < 24'(cyc)) begin
        want = exp_q.pop_front();
        check("missed_event", 32'h0, want);
      end
      kind = {xfer_timeout, wr_ack, wr_start, dma_rd_request};
      if (kind != 4'h0) begin
        got = {24'(cyc), (dma_rd_request ? rd_mac : 4'h0), kind};
        if (exp_q.size() == 0) check("unexpected_event", got, 32'h0);
        else begin
          want = exp_q.pop_front();
          check("event", got, want);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    cnet_reprog = 0; rd_buf_avail = 0; rd_q_vld = 0; rd_q = 0;
    wr_req = 0; wr_mac = 0; cnet_tx_full = 0; ctrl_done = 0;
    wr_pend = 0; wr_mac_r = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // first read of MAC 5, completion, gap
    drive(1, 1, 4'h5, 0, 0, 16'h0, 0, 0);
    quiet(0); quiet(0); quiet(1); quiet(0); quiet(0);

    // reads and a write continuously eligible: rd,rd,wr,...
    for (int i = 0; i < 36; i++)
      drive(1, 1, 4'($urandom_range(0, 15)), 1, 4'd7, 16'h0, (i % 3) == 2, 0);
    quiesce();

    // write blocked by full MAC 3, then released
    repeat (6) drive(0, 0, 4'h0, 1, 4'd3, 16'h0008, 0, 0);
    drive(0, 0, 4'h0, 1, 4'd3, 16'h0000, 0, 0);
    quiet(0); quiet(1); quiet(0); quiet(0);

    // watchdog expiry, then completion exactly on the terminal cycle
    drive(1, 1, 4'hA, 0, 0, 16'h0, 0, 0);
    repeat (12) quiet(0);
    drive(1, 1, 4'hB, 0, 0, 16'h0, 0, 0);
    repeat (7) quiet(0);
    quiet(1); quiet(0); quiet(0);

    // reprogram abort mid-read; pending write granted afterwards
    drive(1, 1, 4'h2, 0, 0, 16'h0, 0, 0);
    quiet(0); quiet(0);
    repeat (3) drive(1, 1, 4'h2, 1, 4'd6, 16'h0, 1, 1);
    drive(0, 0, 4'h0, 1, 4'd6, 16'h0, 0, 0);
    quiet(0); quiet(1); quiet(0); quiet(0);

    // randomized traffic
    repeat (700) rand_cycle();

    // asynchronous reset in the middle of a write transfer
    drive(0, 0, 4'h0, 0, 0, 16'h0, 0, 1);
    drive(0, 0, 4'h0, 0, 0, 16'h0, 0, 1);
`ifdef DMA_XFER_SCHED_STATS_EN
    check("stat_rd_count", rd_count, 32'(m_rd_n));
    check("stat_wr_count", wr_count, 32'(m_wr_n));
    check("stat_timeout_count", timeout_count, 16'(m_to_n));
`endif
    drive(0, 0, 4'h0, 1, 4'd9, 16'h0, 0, 0);
    mon_en = 1'b0;
    @(posedge clk); #2;
    check("wr_start_before_reset", wr_start, 1);
    check("wr_ack_before_reset", wr_ack, 1);
    #1 reset_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    cnet_reprog = 0; rd_buf_avail = 0; rd_q_vld = 0; wr_req = 0; ctrl_done = 0;
    model_reset();
    wr_pend = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (60) rand_cycle();

    // drain and confirm every predicted event was observed
    drive(0, 0, 4'h0, 0, 0, 16'h0, 0, 1);
    drive(0, 0, 4'h0, 0, 0, 16'h0, 0, 1);
    quiet(0);
    @(posedge clk); #1;
    check("leftover_events", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
